// File: rtl/issue_queue.sv
// issue_queue: dual-issue decoded-instruction buffer between decode and launch select.
// Define ISSUE_QUEUE_BYPASS_EN to forward incoming instructions straight to the outputs when empty.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int DEC_W = 72
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stop,
  input  logic                     in1_valid,
  input  logic [PC_W-1:0]          in1_pc,
  input  logic [PC_W-1:0]          in1_npc,
  input  logic [DEC_W-1:0]         in1_decodeout,
  input  logic                     in2_valid,
  input  logic [PC_W-1:0]          in2_pc,
  input  logic [PC_W-1:0]          in2_npc,
  input  logic [DEC_W-1:0]         in2_decodeout,
  output logic                     in_ready,
  output logic [PC_W-1:0]          out1_pc,
  output logic [PC_W-1:0]          out1_npc,
  output logic [DEC_W-1:0]         out1_decodeout,
  output logic                     receive_flag1,
  output logic [PC_W-1:0]          out2_pc,
  output logic [PC_W-1:0]          out2_npc,
  output logic [DEC_W-1:0]         out2_decodeout,
  output logic                     receive_flag2,
  input  logic [1:0]               pop_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * PC_W + DEC_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [EW-1:0] entry1, entry2, firstEntry;
  logic [EW-1:0] wr0Data, wr1Data;
  logic [EW-1:0] out1Entry, out2Entry;
  logic          wr0En, wr1En;
  logic          accept;
  logic          bypassActive;
  logic [1:0]    nPush, nWrite;
  logic [1:0]    popReq, effPop, skip, storePop;
  logic [CW-1:0] avail;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

`ifdef ISSUE_QUEUE_BYPASS_EN
  assign bypassActive = rst && !flush && (count_q == '0);
`else
  assign bypassActive = 1'b0;
`endif

  always_comb begin
    entry1     = {in1_pc, in1_npc, in1_decodeout};
    entry2     = {in2_pc, in2_npc, in2_decodeout};
    firstEntry = in1_valid ? entry1 : entry2;
    nPush      = {1'b0, in1_valid} + {1'b0, in2_valid};
    accept     = in_ready && !flush;
    popReq     = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    avail      = bypassActive ? {{(CW-2){1'b0}}, nPush} : count_q;
    effPop     = 2'd0;
    if (!flush && !stop) begin
      if ({{(CW-2){1'b0}}, popReq} <= avail) effPop = popReq;
      else                                   effPop = avail[1:0];
    end
    // Bypassed instructions already consumed by launch never enter storage.
    skip     = bypassActive ? effPop : 2'd0;
    storePop = bypassActive ? 2'd0 : effPop;
    wr0En    = accept && (nPush > skip);
    wr0Data  = (skip == 2'd0) ? firstEntry : entry2;
    wr1En    = accept && (nPush == 2'd2) && (skip == 2'd0);
    wr1Data  = entry2;
    nWrite   = {1'b0, wr0En} + {1'b0, wr1En};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(storePop);
      tail_d  = tail_q + AW'(nWrite);
      count_d = count_q + CW'(nWrite) - CW'(storePop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0En) mem_q[tail_q]           <= wr0Data;
    if (wr1En) mem_q[tail_q + AW'(1)]  <= wr1Data;
  end

  always_comb begin
    if (bypassActive) begin
      out1Entry     = entry1;
      out2Entry     = entry2;
      receive_flag1 = in1_valid;
      receive_flag2 = in2_valid;
    end else begin
      out1Entry     = mem_q[head_q];
      out2Entry     = mem_q[head_q + AW'(1)];
      receive_flag1 = !flush && (count_q >= CW'(1));
      receive_flag2 = !flush && (count_q >= CW'(2));
    end
    {out1_pc, out1_npc, out1_decodeout} = out1Entry;
    {out2_pc, out2_npc, out2_decodeout} = out2Entry;
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: table-driven directed bench for issue_queue (DEPTH=8), honours ISSUE_QUEUE_BYPASS_EN.
module tb_issue_queue;

`ifdef ISSUE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stop;
  logic        in1_valid, in2_valid;
  logic [31:0] in1_pc, in1_npc, in2_pc, in2_npc;
  logic [71:0] in1_decodeout, in2_decodeout;
  logic        in_ready;
  logic [31:0] out1_pc, out1_npc, out2_pc, out2_npc;
  logic [71:0] out1_decodeout, out2_decodeout;
  logic        receive_flag1, receive_flag2;
  logic [1:0]  pop_cnt;
  logic [3:0]  count;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        flush, stop, v1;
    logic [31:0] pc1;
    logic        v2;
    logic [31:0] pc2;
    logic [1:0]  pop;
    logic [3:0]  cnt;
    logic        f1, f2, rdy;
    logic [31:0] o1, o2;
  } vec_t;

  vec_t vecs[$];

  issue_queue #(.DEPTH(8), .PC_W(32), .DEC_W(72)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stop(stop),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_decodeout(in1_decodeout),
    .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_decodeout(in2_decodeout),
    .in_ready(in_ready),
    .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_decodeout(out1_decodeout), .receive_flag1(receive_flag1),
    .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_decodeout(out2_decodeout), .receive_flag2(receive_flag2),
    .pop_cnt(pop_cnt), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic st, input logic v1, input logic [31:0] p1,
                               input logic v2, input logic [31:0] p2, input logic [1:0] pop);
    flush         = fl;
    stop          = st;
    in1_valid     = v1;
    in1_pc        = p1;
    in1_npc       = p1 + 32'd4;
    in1_decodeout = {40'h0, p1};
    in2_valid     = v2;
    in2_pc        = p2;
    in2_npc       = p2 + 32'd4;
    in2_decodeout = {40'h0, p2};
    pop_cnt       = pop;
  endtask

  task automatic addVec(input logic fl, input logic st, input logic v1, input logic [31:0] p1,
                        input logic v2, input logic [31:0] p2, input logic [1:0] pop,
                        input logic [3:0] cnt, input logic f1, input logic f2, input logic rdy,
                        input logic [31:0] o1, input logic [31:0] o2);
    vec_t v;
    v.flush = fl; v.stop = st; v.v1 = v1; v.pc1 = p1; v.v2 = v2; v.pc2 = p2; v.pop = pop;
    v.cnt = cnt; v.f1 = f1; v.f2 = f2; v.rdy = rdy; v.o1 = o1; v.o2 = o2;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs driven before the edge, expected outputs seen before that same edge.
    addVec(0,0, 1,32'h100, 1,32'h104, 0,  4'd0, BYP, BYP, 1, 32'h100, 32'h104);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd2, 1, 1, 1, 32'h100, 32'h104);
    addVec(0,0, 0,32'h0,   0,32'h0,   2,  4'd2, 1, 1, 1, 32'h100, 32'h104);
    addVec(0,0, 1,32'h110, 1,32'h114, 0,  4'd0, BYP, BYP, 1, 32'h110, 32'h114);
    addVec(0,0, 1,32'h118, 1,32'h11C, 0,  4'd2, 1, 1, 1, 32'h110, 32'h114);
    addVec(0,0, 1,32'h120, 1,32'h124, 0,  4'd4, 1, 1, 1, 32'h110, 32'h114);
    addVec(0,0, 1,32'h128, 0,32'h0,   0,  4'd6, 1, 1, 1, 32'h110, 32'h114);
    addVec(0,0, 1,32'h12C, 1,32'h130, 0,  4'd7, 1, 1, 0, 32'h110, 32'h114);
    addVec(0,0, 0,32'h0,   0,32'h0,   2,  4'd7, 1, 1, 0, 32'h110, 32'h114);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd5, 1, 1, 1, 32'h118, 32'h11C);
    addVec(0,0, 0,32'h0,   0,32'h0,   2,  4'd5, 1, 1, 1, 32'h118, 32'h11C);
    addVec(0,0, 0,32'h0,   0,32'h0,   2,  4'd3, 1, 1, 1, 32'h120, 32'h124);
    addVec(0,0, 1,32'h140, 1,32'h144, 2,  4'd1, 1, 0, 1, 32'h128, 32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd2, 1, 1, 1, 32'h140, 32'h144);
    addVec(0,0, 0,32'h0,   0,32'h0,   1,  4'd2, 1, 1, 1, 32'h140, 32'h144);
    addVec(0,1, 1,32'h150, 1,32'h154, 2,  4'd1, 1, 0, 1, 32'h144, 32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd3, 1, 1, 1, 32'h144, 32'h150);
    addVec(0,0, 1,32'h158, 1,32'h15C, 0,  4'd3, 1, 1, 1, 32'h144, 32'h150);
    addVec(1,1, 1,32'h160, 1,32'h164, 2,  4'd5, 0, 0, 1, 32'h0,   32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd0, 0, 0, 1, 32'h0,   32'h0);
    addVec(0,0, 1,32'h200, 0,32'h0,   0,  4'd0, BYP, 0, 1, 32'h200, 32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd1, 1, 0, 1, 32'h200, 32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   1,  4'd1, 1, 0, 1, 32'h200, 32'h0);
    addVec(0,0, 0,32'h0,   0,32'h0,   0,  4'd0, 0, 0, 1, 32'h0,   32'h0);

    rst = 1'b0;
    applyStimulus(0, 0, 1, 32'h500, 1, 32'h504, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset flag1", 32'(receive_flag1), 32'd0);
    checkOutput("reset flag2", 32'(receive_flag2), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].flush, vecs[i].stop, vecs[i].v1, vecs[i].pc1,
                    vecs[i].v2, vecs[i].pc2, vecs[i].pop);
      #1;
      checkOutput($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].cnt));
      checkOutput($sformatf("row%0d flag1", i), 32'(receive_flag1), 32'(vecs[i].f1));
      checkOutput($sformatf("row%0d flag2", i), 32'(receive_flag2), 32'(vecs[i].f2));
      checkOutput($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      if (vecs[i].f1) begin
        checkOutput($sformatf("row%0d out1_pc", i), out1_pc, vecs[i].o1);
        checkOutput($sformatf("row%0d out1_npc", i), out1_npc, vecs[i].o1 + 32'd4);
      end
      if (vecs[i].f2) checkOutput($sformatf("row%0d out2_pc", i), out2_pc, vecs[i].o2);
    end

    // Empty queue, push two and pop one in the same cycle.
    @(negedge clk);
    applyStimulus(0, 0, 1, 32'h300, 1, 32'h304, 1);
    #1;
    checkOutput("bypass flag1", 32'(receive_flag1), 32'(BYP));
    checkOutput("bypass flag2", 32'(receive_flag2), 32'(BYP));
    if (BYP) checkOutput("bypass out1_pc", out1_pc, 32'h300);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    checkOutput("after bypass count", 32'(count), BYP ? 32'd1 : 32'd2);
    checkOutput("after bypass flag1", 32'(receive_flag1), 32'd1);
    checkOutput("after bypass out1_pc", out1_pc, BYP ? 32'h304 : 32'h300);
    checkOutput("after bypass flag2", 32'(receive_flag2), BYP ? 32'd0 : 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
